// File: rtl/hazard_pkg.sv
// Shared types and stage-control constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_en;
    logic memwb_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN      = 6'b110010;
  localparam stage_ctrl_t CTRL_FREEZE   = 6'b000001;
  localparam stage_ctrl_t CTRL_KILL_ALL = 6'b001101;

  // Only count a hazard when the load actually writes a real register.
  function automatic logic load_use_hit(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2
  );
    return ex_mem_read && (ex_rd != 5'd0) &&
           ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the debug stall/flush statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] out
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign out = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use stalls, EX redirects, memory-wait freeze
// with watchdog, plus saturating debug counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic [1:0]       state,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  hz_state_e   state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic        err_q, err_d;
  stage_ctrl_t ctrl;
  logic        run_rules, stall_inc, flush_inc, lu_hit;

  assign lu_hit = load_use_hit(ex_mem_read, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    err_d     = err_q;
    ctrl      = CTRL_KILL_ALL;
    run_rules = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          ctrl    = CTRL_FREEZE;
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          ctrl = CTRL_FREEZE;
          if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          // Release cycle: a redirect held in EX during the freeze fires now.
          run_rules = 1'b1;
          state_d   = ST_RUN;
          wait_d    = '0;
        end
      end
      ST_ERROR: ;
    endcase

    if (run_rules) begin
      ctrl = CTRL_RUN;
      if (ex_redirect) begin
        // Wrong-path instructions in IF/ID are squashed; a load-use on them is moot.
        ctrl.ifid_flush = 1'b1;
        ctrl.idex_flush = 1'b1;
        flush_inc       = 1'b1;
      end else if (lu_hit) begin
        ctrl.pc_en      = 1'b0;
        ctrl.ifid_en    = 1'b0;
        ctrl.idex_flush = 1'b1;
      end
    end

    stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !ctrl.pc_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall_inc), .out(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush_inc), .out(flush_cnt)
  );

  assign pc_en           = ctrl.pc_en;
  assign ifid_en         = ctrl.ifid_en;
  assign ifid_flush      = ctrl.ifid_flush;
  assign idex_flush      = ctrl.idex_flush;
  assign exmem_en        = ctrl.exmem_en;
  assign memwb_flush     = ctrl.memwb_flush;
  assign state           = state_q;
  assign mem_timeout_err = err_q;

endmodule
